// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus used by the fetch stage.
// The fetch stage drives the request side (master); the memory answers (slave).
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request at a time, PC advance
// on grant, IF/ID register load with instr/pc/pc+4, one-entry hold buffer for
// ID stalls, and wrong-path discard on flush.
module if_fetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              fetch_pc_write_o,
    if_fetch_stage_if.master  bus,
    input  logic              id_stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0] if_id_pc_o,
    output logic [ADDR_W-1:0] if_id_pc_plus_4_o,
    output logic              if_id_valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(4);

    state_t            state_q;
    logic              req_q;
    logic              discard_q;
    logic [ADDR_W-1:0] req_pc_q;
    logic [DATA_W-1:0] hold_instr_q;

    logic [DATA_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic [ADDR_W-1:0] if_id_pc_plus_4_q, if_id_pc_plus_4_d;
    logic              if_id_valid_q, if_id_valid_d;

    logic              grant;
    logic              load_wait;
    logic              load_hold;
    logic [DATA_W-1:0] load_instr;

    // A grant only counts while a request is actually being presented.
    assign grant     = (state_q == REQ) && bus.imem_gnt;
    // Fresh data goes straight to IF/ID unless it is wrong-path or ID is stalled.
    assign load_wait = (state_q == WAIT) && bus.imem_rvalid && !discard_q &&
                       !flush_i && !id_stall_i;
    assign load_hold = (state_q == HOLD) && !flush_i && !id_stall_i;
    assign load_instr = load_hold ? hold_instr_q : bus.imem_rdata;

    // A redirect must always be able to load the PC, even mid-transaction.
    assign fetch_pc_write_o = grant || flush_i;

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = req_q ? pc_i : '0;

    // Fetch control FSM; imem_req is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        state_q   <= WAIT;
                        req_q     <= 1'b0;
                        discard_q <= flush_i;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        discard_q <= 1'b0;
                        if (discard_q || flush_i || !id_stall_i) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush_i || !id_stall_i) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    req_q     <= 1'b0;
                    discard_q <= 1'b0;
                end
            endcase
        end
    end

    // Request address and hold buffer; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (grant) begin
            req_pc_q <= pc_i;
        end
        if ((state_q == WAIT) && bus.imem_rvalid) begin
            hold_instr_q <= bus.imem_rdata;
        end
    end

    // IF/ID next state: flush beats stall beats load beats bubble.
    always_comb begin
        if_id_instr_d     = if_id_instr_q;
        if_id_pc_d        = if_id_pc_q;
        if_id_pc_plus_4_d = if_id_pc_plus_4_q;
        if_id_valid_d     = if_id_valid_q;
        if (flush_i) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (!id_stall_i) begin
            if (load_wait || load_hold) begin
                if_id_instr_d     = load_instr;
                if_id_pc_d        = req_pc_q;
                if_id_pc_plus_4_d = req_pc_q + INSTR_BYTES;
                if_id_valid_d     = 1'b1;
            end else begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr_q     <= NOP_INSTR;
            if_id_pc_q        <= '0;
            if_id_pc_plus_4_q <= '0;
            if_id_valid_q     <= 1'b0;
        end else begin
            if_id_instr_q     <= if_id_instr_d;
            if_id_pc_q        <= if_id_pc_d;
            if_id_pc_plus_4_q <= if_id_pc_plus_4_d;
            if_id_valid_q     <= if_id_valid_d;
        end
    end

    assign if_id_instr_o     = if_id_instr_q;
    assign if_id_pc_o        = if_id_pc_q;
    assign if_id_pc_plus_4_o = if_id_pc_plus_4_q;
    assign if_id_valid_o     = if_id_valid_q;

endmodule
